// File: rtl/mux_arbiter_2x1.sv
// mux_arbiter_2x1: two-requester arbiter feeding a registered 2:1 select onto a valid/ready output (MUX_ARB_FIXED_PRIORITY_EN selects fixed priority)
module mux_arbiter_2x1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt1,
    input  logic             req2,
    input  logic [WIDTH-1:0] d2,
    output logic             gnt2,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;
    state_t state, state_nxt;
    logic last_two;
    logic sel_q;
    logic slot_free;
    logic pick1;
    // Arbitrate while the slot is free and derive select and next state
    always_comb begin
        out_valid = state != EMPTY;
        slot_free = !out_valid || out_ready;
`ifdef MUX_ARB_FIXED_PRIORITY_EN
        pick1     = req1;
`else
        pick1     = req1 && (!req2 || last_two);
`endif
        gnt1      = rst_n && slot_free && pick1;
        gnt2      = rst_n && slot_free && req2 && !pick1;
        sel       = gnt1 ? 1'b1 : gnt2 ? 1'b0 : sel_q;
        state_nxt = gnt1 ? FULL1 : gnt2 ? FULL2 : (out_valid && out_ready) ? EMPTY : state;
    end
    // Capture the granted word and arbitration history; reset discards the held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            last_two <= 1'b1;
            sel_q    <= 1'b1;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (gnt1 || gnt2) begin
                last_two <= gnt2;
                sel_q    <= sel;
                out_data <= gnt1 ? d1 : d2;
            end
        end
    end
endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// tb_mux_arbiter_2x1: directed and random checks of mux_arbiter_2x1 against a transaction-level model
module tb_mux_arbiter_2x1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req1 = 1'b0;
    logic        req2 = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] d1 = '0;
    logic [15:0] d2 = '0;
    logic        gnt1, gnt2, sel, out_valid;
    logic [15:0] out_data;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_last;
    bit          m_sel;
    bit          fixed_prio;

    mux_arbiter_2x1 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .d1(d1), .gnt1(gnt1),
        .req2(req2), .d2(d2), .gnt2(gnt2),
        .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 2;
        m_sel   = 1'b1;
    endtask

    // One cycle: drive inputs, check at the falling edge, advance model at the rising edge
    task automatic step(input bit r1, input bit r2, input logic [15:0] a, input logic [15:0] b,
                        input bit rdy, output int g);
        bit free;
        g = 0;
        req1 = r1; req2 = r2; d1 = a; d2 = b; out_ready = rdy;
        @(negedge clk);
        free = !m_valid || rdy;
        if (free) begin
            if (r1 && r2) g = fixed_prio ? 1 : (m_last == 1 ? 2 : 1);
            else if (r1) g = 1;
            else if (r2) g = 2;
        end
        chk("gnt1", {15'd0, gnt1}, {15'd0, g == 1});
        chk("gnt2", {15'd0, gnt2}, {15'd0, g == 2});
        chk("sel", {15'd0, sel}, {15'd0, g == 1 ? 1'b1 : g == 2 ? 1'b0 : m_sel});
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
        chk("out_data", out_data, m_data);
        @(posedge clk);
        if (g != 0) begin
            m_data  = g == 1 ? a : b;
            m_valid = 1'b1;
            m_last  = g;
            m_sel   = g == 1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        int g;
        bit p1, p2;
        logic [15:0] v1, v2;
`ifdef MUX_ARB_FIXED_PRIORITY_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        model_reset();
        req1 = 1'b1; req2 = 1'b1;
        @(negedge clk);
        chk("rst_gnt1", {15'd0, gnt1}, 16'd0);
        chk("rst_gnt2", {15'd0, gnt2}, 16'd0);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_sel", {15'd0, sel}, 16'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        step(1, 1, 16'h0101, 16'h0202, 1, g);
        chk("first_grant", g[15:0], 16'd1);
        step(0, 0, 16'h0, 16'h0, 1, g);
        step(1, 0, 16'hA5A5, 16'h0, 1, g);
        step(0, 0, 16'h0, 16'h0, 1, g);
        for (int i = 0; i < 4; i++) step(1, 1, 16'h1111, 16'h2222, 1, g);
        step(0, 0, 16'h0, 16'h0, 1, g);
        step(1, 0, 16'h3333, 16'h0, 1, g);
        for (int i = 0; i < 3; i++) step(1, 1, 16'h4444, 16'h5555, 0, g);
        step(1, 1, 16'h4444, 16'h5555, 1, g);
        step(0, 1, 16'h0, 16'h5555, 0, g);
        step(0, 1, 16'h0, 16'h5555, 1, g);
        step(0, 0, 16'h0, 16'h0, 1, g);
        step(1, 0, 16'hBEEF, 16'h0, 1, g);
        step(0, 0, 16'h0, 16'h0, 0, g);
        req1 = 1'b1; req2 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {15'd0, out_valid}, 16'd0);
        chk("midrst_data", out_data, 16'h0000);
        chk("midrst_gnt", {14'd0, gnt1, gnt2}, 16'd0);
        #2 rst_n = 1'b1;
        model_reset();
        step(1, 1, 16'h6666, 16'h7777, 1, g);
        chk("midrst_winner", g[15:0], 16'd1);
        p1 = 1'b0; p2 = 1'b0; v1 = '0; v2 = '0;
        for (int i = 0; i < 300; i++) begin
            if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1'b1; v1 = 16'($urandom); end
            if (!p2 && $urandom_range(0, 2) != 0) begin p2 = 1'b1; v2 = 16'($urandom); end
            step(p1, p2, v1, v2, $urandom_range(0, 3) != 0, g);
            if (g == 1) p1 = 1'b0;
            if (g == 2) p2 = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
